v8_pulse_gen: RTL and testbench

//  Test-signal source for the v8 shaping-filter chain. Emits ADC-format samples: a baseline plus

---
 rtl/v8_pulse_gen.sv | 141 ++++++++++++++
 tb/tb_v8_pulse_gen.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/v8_pulse_gen.sv
// Test-signal source for the v8 shaping-filter chain: a baseline plus bursts of
// instant-rise, exponentially decaying pulses in signed ADC format.
module v8_pulse_gen #(
    parameter int SIZE_ADC_DATA = 14,
    parameter int FRAC_BITS     = 8,
    parameter int DECAY_SHIFT   = 4,
    parameter int BASELINE      = 0,
    parameter int PERIOD_W      = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [SIZE_ADC_DATA-2:0]        amplitude,
    input  logic [7:0]                      n_pulses,
    input  logic [PERIOD_W-1:0]             period,
    output logic signed [SIZE_ADC_DATA-1:0] adc_data,
    output logic                            pulse_strobe,
    output logic                            busy,
    output logic                            done
);

    localparam int ACC_W = SIZE_ADC_DATA - 1 + FRAC_BITS + 2;
    localparam int PAD_W = ACC_W - (SIZE_ADC_DATA - 1) - FRAC_BITS;
    localparam int SMAX  = (2 ** (SIZE_ADC_DATA - 1)) - 1;
    localparam int SMIN  = -(2 ** (SIZE_ADC_DATA - 1));

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                     state_q, state_d;
    logic [ACC_W-1:0]           acc_q, acc_d;
    logic [SIZE_ADC_DATA-2:0]   amp_q, amp_d;
    logic [7:0]                 left_q, left_d;
    logic [PERIOD_W-1:0]        per_max_q, per_max_d;
    logic [PERIOD_W-1:0]        per_cnt_q, per_cnt_d;
    logic                       inject_q, inject_d;
    logic                       fin_q, fin_d;
    logic signed [SIZE_ADC_DATA-1:0] adc_q, adc_d;
    logic                       strobe_q, done_q;

    logic [ACC_W-1:0]           amp_in_ext, amp_ext;
    logic [ACC_W-1:0]           acc_decay;
    logic [ACC_W:0]             acc_inj;
    logic [ACC_W-1:0]           acc_inj_sat;
    logic                       decay_int_zero;
    int                         sample;

    assign amp_in_ext     = {{PAD_W{1'b0}}, amplitude, {FRAC_BITS{1'b0}}};
    assign amp_ext        = {{PAD_W{1'b0}}, amp_q, {FRAC_BITS{1'b0}}};
    assign acc_decay      = acc_q - (acc_q >> DECAY_SHIFT);
    assign acc_inj        = {1'b0, acc_decay} + {1'b0, amp_ext};
    // Heavy pile-up clamps the accumulator rather than letting it wrap.
    assign acc_inj_sat    = acc_inj[ACC_W] ? '1 : acc_inj[ACC_W-1:0];
    assign decay_int_zero = (acc_decay[ACC_W-1:FRAC_BITS] == '0);

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        amp_d     = amp_q;
        left_d    = left_q;
        per_max_d = per_max_q;
        per_cnt_d = per_cnt_q;
        inject_d  = 1'b0;
        fin_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && (n_pulses != 8'd0)) begin
                    state_d   = S_RUN;
                    amp_d     = amplitude;
                    left_d    = n_pulses - 8'd1;
                    per_max_d = (period == '0) ? '0 : period - PERIOD_W'(1);
                    per_cnt_d = '0;
                    acc_d     = amp_in_ext;
                    inject_d  = 1'b1;
                end
            end
            S_RUN: begin
                if ((left_q != 8'd0) && (per_cnt_q == per_max_q)) begin
                    acc_d     = acc_inj_sat;
                    left_d    = left_q - 8'd1;
                    per_cnt_d = '0;
                    inject_d  = 1'b1;
                end else if ((left_q == 8'd0) && decay_int_zero) begin
                    acc_d   = '0;
                    state_d = S_IDLE;
                    fin_d   = 1'b1;
                end else begin
                    acc_d = acc_decay;
                    if (per_cnt_q != '1) begin
                        per_cnt_d = per_cnt_q + PERIOD_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sample = BASELINE + int'(acc_q >> FRAC_BITS);
        adc_d  = SIZE_ADC_DATA'(sample);
        if (sample > SMAX) begin
            adc_d = SIZE_ADC_DATA'(SMAX);
        end else if (sample < SMIN) begin
            adc_d = SIZE_ADC_DATA'(SMIN);
        end
    end

    // Output stage lags the accumulator by one clk; strobe and done ride along.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            amp_q     <= '0;
            left_q    <= '0;
            per_max_q <= '0;
            per_cnt_q <= '0;
            inject_q  <= 1'b0;
            fin_q     <= 1'b0;
            adc_q     <= SIZE_ADC_DATA'(BASELINE);
            strobe_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            amp_q     <= amp_d;
            left_q    <= left_d;
            per_max_q <= per_max_d;
            per_cnt_q <= per_cnt_d;
            inject_q  <= inject_d;
            fin_q     <= fin_d;
            adc_q     <= adc_d;
            strobe_q  <= inject_q;
            done_q    <= fin_q;
        end
    end

    assign adc_data     = adc_q;
    assign pulse_strobe = strobe_q;
    assign busy         = (state_q == S_RUN);
    assign done         = done_q;

endmodule

// File: tb/tb_v8_pulse_gen.sv
// Self-checking bench for v8_pulse_gen: directed protocol steps plus random bursts
// compared against a burst-level trace model built from the pulse rules.
module tb_v8_pulse_gen;

    localparam longint ACC_MAX = (longint'(1) << 23) - 1;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               start = 1'b0;
    logic [12:0]        amplitude = '0;
    logic [7:0]         n_pulses = '0;
    logic [15:0]        period = '0;
    logic signed [13:0] adc_data;
    logic               pulse_strobe;
    logic               busy;
    logic               done;

    int n_cmp  = 0;
    int n_fail = 0;

    longint m_acc[$];
    bit     m_inj[$];
    int     m_T;
    int     q_adc[$];
    int     q_strobe_e[$];
    int     cnt_done;

    always #5 clk = ~clk;

    v8_pulse_gen dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .amplitude    (amplitude),
        .n_pulses     (n_pulses),
        .period       (period),
        .adc_data     (adc_data),
        .pulse_strobe (pulse_strobe),
        .busy         (busy),
        .done         (done)
    );

    task automatic check(input string tag, input int e, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s e=%0d observed=%0d expected=%0d", tag, e, obs, exp);
        end
    endtask

    function automatic int sat_out(input longint acc);
        longint s;
        s = acc / 256;
        if (s > 8191) s = 8191;
        if (s < -8192) s = -8192;
        return int'(s);
    endfunction

    // Whole-burst trace: accumulator after each edge t (t=0 is the start edge),
    // pulses injected at t = k*period, finish edge m_T when the tail integer hits 0.
    task automatic model_burst(input int amp, input int n, input int per);
        int     p;
        longint acc;
        int     injected;
        p = (per < 1) ? 1 : per;
        m_acc.delete();
        m_inj.delete();
        acc      = longint'(amp) * 256;
        injected = 1;
        m_acc.push_back(acc);
        m_inj.push_back(1'b1);
        m_T = -1;
        for (int t = 1; t < 50000; t++) begin
            if (injected < n && t == injected * p) begin
                acc = acc - acc / 16 + longint'(amp) * 256;
                if (acc > ACC_MAX) acc = ACC_MAX;
                injected++;
                m_acc.push_back(acc);
                m_inj.push_back(1'b1);
            end else if (injected == n && (acc - acc / 16) / 256 == 0) begin
                m_acc.push_back(0);
                m_inj.push_back(1'b0);
                m_T = t;
                break;
            end else begin
                acc = acc - acc / 16;
                m_acc.push_back(acc);
                m_inj.push_back(1'b0);
            end
        end
    endtask

    task automatic run_burst(input int amp, input int n, input int per,
                             input int poke_at, input int abort_at);
        int adc_e, stb_e, busy_e, done_e, poke;
        model_burst(amp, n, per);
        q_adc.delete();
        q_strobe_e.delete();
        cnt_done = 0;
        poke = (poke_at > m_T) ? 0 : poke_at;
        amplitude = 13'(amp);
        n_pulses  = 8'(n);
        period    = 16'(per);
        start     = 1'b1;
        if (m_T < 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL model_bound e=0 observed=%0d expected=%0d", m_T, 1);
            start = 1'b0;
            return;
        end
        for (int e = 0; e <= m_T + 1; e++) begin
            @(posedge clk);
            #1;
            start = (e + 1 == poke);
            if (start) begin
                amplitude = 13'($urandom);
                n_pulses  = 8'($urandom_range(1, 255));
                period    = 16'($urandom_range(0, 3));
            end
            adc_e  = (e == 0) ? 0 : sat_out(m_acc[e-1]);
            stb_e  = (e == 0) ? 0 : int'(m_inj[e-1]);
            busy_e = (e < m_T) ? 1 : 0;
            done_e = (e == m_T + 1) ? 1 : 0;
            check("adc_data", e, adc_data, adc_e);
            check("pulse_strobe", e, {31'b0, pulse_strobe}, stb_e);
            check("busy", e, {31'b0, busy}, busy_e);
            check("done", e, {31'b0, done}, done_e);
            q_adc.push_back(int'(adc_data));
            if (pulse_strobe) q_strobe_e.push_back(e);
            if (done) cnt_done++;
            if (e == abort_at) begin
                start = 1'b0;
                return;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int a, n, p;

        // Reset held with start toggling: nothing leaves idle.
        amplitude = 13'd1000;
        n_pulses  = 8'd1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            start = ~start;
            check("rst_adc", i, adc_data, 0);
            check("rst_busy", i, {31'b0, busy}, 0);
            check("rst_done", i, {31'b0, done}, 0);
            check("rst_strobe", i, {31'b0, pulse_strobe}, 0);
        end
        start = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Single pulse with known sample values.
        run_burst(1000, 1, 5, 0, -1);
        check("single_s1", 1, q_adc[1], 1000);
        check("single_s2", 2, q_adc[2], 937);
        check("single_s3", 3, q_adc[3], 878);
        check("single_strobes", 0, q_strobe_e.size(), 1);
        check("single_done", 0, cnt_done, 1);
        check("single_final", 0, q_adc[q_adc.size()-1], 0);

        // Burst with pile-up.
        run_burst(500, 3, 20, 0, -1);
        check("burst_strobes", 0, q_strobe_e.size(), 3);
        if (q_strobe_e.size() == 3) begin
            check("burst_gap1", 0, q_strobe_e[1] - q_strobe_e[0], 20);
            check("burst_gap2", 0, q_strobe_e[2] - q_strobe_e[1], 20);
            check("burst_peak2", 0, {31'b0, q_adc[q_strobe_e[1]] > 500}, 1);
            check("burst_peak3", 0, {31'b0, q_adc[q_strobe_e[2]] > 500}, 1);
        end
        check("burst_done", 0, cnt_done, 1);

        // Output saturation, then accumulator clamp under long pile-up.
        run_burst(8000, 2, 1, 0, -1);
        check("sat_s1", 1, q_adc[1], 8000);
        check("sat_s2", 2, q_adc[2], 8191);
        run_burst(8191, 8, 1, 0, -1);

        // Start with n_pulses=0 is ignored.
        amplitude = 13'd300;
        n_pulses  = 8'd0;
        start     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            check("n0_busy", i, {31'b0, busy}, 0);
            check("n0_adc", i, adc_data, 0);
        end

        // Start during busy ignored; period=0 behaves as period=1.
        run_burst(400, 2, 15, 5, -1);
        run_burst(300, 3, 0, 2, -1);
        check("p0_gap", 0, q_strobe_e.size() == 3 ? q_strobe_e[2] - q_strobe_e[1] : -1, 1);

        // Reset mid-burst after the second strobe.
        run_burst(700, 5, 10, 0, 12);
        check("abort_strobes", 0, q_strobe_e.size(), 2);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("abort_adc", 0, adc_data, 0);
        check("abort_busy", 0, {31'b0, busy}, 0);
        check("abort_done", 0, {31'b0, done}, 0);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            check("abort_quiet", i, {30'b0, done, pulse_strobe}, 0);
        end
        run_burst(600, 2, 7, 0, -1);

        // Random bursts, each poked with a start while busy.
        for (int k = 0; k < 8; k++) begin
            a = int'($urandom_range(0, 8191));
            n = int'($urandom_range(1, 4));
            p = int'($urandom_range(0, 40));
            run_burst(a, n, p, 3, -1);
            $display("burst amp=%0d n=%0d period=%0d len=%0d strobes=%0d", a, n, p, m_T,
                     q_strobe_e.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
